// File: rtl/id_ex_pipe_reg.sv
// Decode->Execute pipeline register: captures the D-stage control word and
// operands and presents them to EX one cycle later.
// Ports: clk, rst_n (async active-low), StallE/FlushE from the hazard unit,
// <name>D inputs from decode, <name>E registered copies, ValidE, IllegalE.
module id_ex_pipe_reg #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic [1:0]      ResultSrcD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic [3:0]      ALUControlD,
    input  logic [1:0]      ALUSrcD,
    input  logic [2:0]      funct3D,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    output logic            ValidE,
    output logic            IllegalE,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [3:0]      ALUControlE,
    output logic [1:0]      ALUSrcE,
    output logic [2:0]      funct3E,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic [REGW-1:0] RdE
);

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic [3:0]      alu_ctrl;
        logic [1:0]      alu_src;
        logic [2:0]      funct3;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm_ext;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
    } ex_t;

    ex_t  ex_q;
    ex_t  ex_d;
    logic alu_legal;

    // X/Z bits match no item and fall into the default, so they are
    // treated as illegal in simulation as well.
    always_comb begin
        alu_legal = 1'b0;
        case (ALUControlD)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1011, 4'b1100: alu_legal = 1'b1;
            default:                            alu_legal = 1'b0;
        endcase
    end

    // Flush beats stall so a hazard-unit bubble is never lost.
    always_comb begin
        ex_d = ex_q;
        if (FlushE) begin
            ex_d = '0;
        end else if (StallE) begin
            ex_d = ex_q;
        end else if (!ValidD) begin
            ex_d = '0;
        end else if (!alu_legal) begin
            // Flagged bubble keeps only the PC so a trap can report it.
            ex_d         = '0;
            ex_d.illegal = 1'b1;
            ex_d.pc      = PCD;
        end else begin
            ex_d.valid      = 1'b1;
            ex_d.illegal    = 1'b0;
            ex_d.reg_write  = RegWriteD;
            ex_d.result_src = ResultSrcD;
            ex_d.mem_write  = MemWriteD;
            ex_d.jump       = JumpD;
            ex_d.branch     = BranchD;
            ex_d.alu_ctrl   = ALUControlD;
            ex_d.alu_src    = ALUSrcD;
            ex_d.funct3     = funct3D;
            ex_d.rd1        = RD1D;
            ex_d.rd2        = RD2D;
            ex_d.pc         = PCD;
            ex_d.pc_plus4   = PCPlus4D;
            ex_d.imm_ext    = ImmExtD;
            ex_d.rs1        = Rs1D;
            ex_d.rs2        = Rs2D;
            ex_d.rd         = RdD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ValidE      = ex_q.valid;
    assign IllegalE    = ex_q.illegal;
    assign RegWriteE   = ex_q.reg_write;
    assign ResultSrcE  = ex_q.result_src;
    assign MemWriteE   = ex_q.mem_write;
    assign JumpE       = ex_q.jump;
    assign BranchE     = ex_q.branch;
    assign ALUControlE = ex_q.alu_ctrl;
    assign ALUSrcE     = ex_q.alu_src;
    assign funct3E     = ex_q.funct3;
    assign RD1E        = ex_q.rd1;
    assign RD2E        = ex_q.rd2;
    assign PCE         = ex_q.pc;
    assign PCPlus4E    = ex_q.pc_plus4;
    assign ImmExtE     = ex_q.imm_ext;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;
    assign RdE         = ex_q.rd;

endmodule
